// File: rtl/composite_luma_encoder_if.sv
// Bundle between the composite sync/timing generator, the pixel source and the luma encoder.
// Timing strobes and luma flow towards the encoder; DAC pins and the error flag flow back.
// The master drives the timing/luma side; the slave is the encoder.
interface composite_luma_encoder_if;
   logic       sync_in;
   logic       active_in;
   logic       line_start;
   logic       pixel_strobe;
   logic [7:0] luma_in;
   logic       output_450ohm;
   logic       output_900ohm;
   logic       protocol_error;

   modport master (
      output sync_in, active_in, line_start, pixel_strobe, luma_in,
      input  output_450ohm, output_900ohm, protocol_error
   );

   modport slave (
      input  sync_in, active_in, line_start, pixel_strobe, luma_in,
      output output_450ohm, output_900ohm, protocol_error
   );
endinterface

// File: rtl/composite_luma_encoder.sv
// Quantises 8-bit luma onto a 3-level resistor DAC with per-line 1-D error diffusion.
// Latency: exactly 2 clk cycles from every input to the DAC pins and protocol_error.
// Backpressure: none; timing is dictated upstream. Macro COMPOSITE_TEST_BARS_EN replaces luma with 8 vertical bars.
module composite_luma_encoder #(
   parameter int THRESH_LO  = 64,
   parameter int THRESH_HI  = 192,
   parameter int GREY_VALUE = 128
) (
   input  logic                     clk,
   input  logic                     reset,
   composite_luma_encoder_if.slave  bus
);

   // Level codes as driven onto {output_450ohm, output_900ohm}
   localparam logic [1:0] CODE_SYNC  = 2'b00;
   localparam logic [1:0] CODE_BLACK = 2'b01;
   localparam logic [1:0] CODE_GREY  = 2'b10;
   localparam logic [1:0] CODE_WHITE = 2'b11;

   localparam logic signed [9:0]  TH_LO     = 10'(THRESH_LO);
   localparam logic signed [9:0]  TH_HI     = 10'(THRESH_HI);
   localparam logic signed [10:0] LVL_BLACK = 11'sd0;
   localparam logic signed [10:0] LVL_GREY  = 11'(GREY_VALUE);
   localparam logic signed [10:0] LVL_WHITE = 11'sd255;
   localparam logic signed [10:0] SAT_MAX   = 11'sd127;
   localparam logic signed [10:0] SAT_MIN   = -11'sd128;

   // Stage 1: registered copy of the timing strobes and luma
   logic        s1_sync;
   logic        s1_active;
   logic        s1_line_start;
   logic        s1_strobe;
`ifndef COMPOSITE_TEST_BARS_EN
   logic [7:0]  s1_luma;
`endif

   // Diffusion state and stage-2 registered outputs
   logic signed [7:0] err_q;
   logic [1:0]        held_q;
   logic [1:0]        pin_code_q;
   logic              perr_q;

`ifdef COMPOSITE_TEST_BARS_EN
   logic [7:0]        cnt_q;
   logic [7:0]        cnt_base;
   logic [7:0]        cnt_d;
`endif

   logic signed [7:0]  err_base;
   logic [1:0]         held_base;
   logic [7:0]         luma_eff;
   logic               pix_take;
   logic signed [9:0]  acc;
   logic [1:0]         pix_code;
   logic signed [10:0] level;
   logic signed [10:0] diff;
   logic signed [7:0]  err_sat;
   logic signed [7:0]  err_d;
   logic [1:0]         held_d;
   logic [1:0]         pin_code_d;
   logic               perr_d;

   // Stage-2 datapath: line clear first, then quantise an active strobe, then pick the pin level
   always_comb begin
      err_base  = err_q;
      held_base = held_q;
      if (s1_line_start) begin
         err_base  = '0;
         held_base = CODE_BLACK;
      end

`ifdef COMPOSITE_TEST_BARS_EN
      cnt_base = s1_line_start ? 8'd0 : cnt_q;
      luma_eff = {cnt_base[7:5], cnt_base[7:5], cnt_base[7:6]};
`else
      luma_eff = s1_luma;
`endif

      pix_take = s1_strobe & s1_active;
      acc      = $signed({2'b00, luma_eff}) + $signed({{2{err_base[7]}}, err_base});

      if (acc >= TH_HI) begin
         pix_code = CODE_WHITE;
         level    = LVL_WHITE;
      end else if (acc >= TH_LO) begin
         pix_code = CODE_GREY;
         level    = LVL_GREY;
      end else begin
         pix_code = CODE_BLACK;
         level    = LVL_BLACK;
      end

      diff = $signed({acc[9], acc}) - level;
      if (diff > SAT_MAX) begin
         err_sat = 8'sh7f;
      end else if (diff < SAT_MIN) begin
         err_sat = 8'sh80;
      end else begin
         err_sat = diff[7:0];
      end

      err_d  = pix_take ? err_sat  : err_base;
      held_d = pix_take ? pix_code : held_base;

`ifdef COMPOSITE_TEST_BARS_EN
      cnt_d = pix_take ? cnt_base + 8'd1 : cnt_base;
`endif

      if (s1_sync) begin
         pin_code_d = CODE_SYNC;
      end else if (!s1_active) begin
         pin_code_d = CODE_BLACK;
      end else begin
         pin_code_d = held_d;
      end

      perr_d = perr_q | (s1_strobe & ~s1_active);
   end

   // Both pipeline stages and the diffusion state; reset discards everything in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_sync       <= 1'b0;
         s1_active     <= 1'b0;
         s1_line_start <= 1'b0;
         s1_strobe     <= 1'b0;
`ifndef COMPOSITE_TEST_BARS_EN
         s1_luma       <= 8'd0;
`endif
         err_q         <= '0;
         held_q        <= CODE_BLACK;
         pin_code_q    <= CODE_SYNC;
         perr_q        <= 1'b0;
`ifdef COMPOSITE_TEST_BARS_EN
         cnt_q         <= 8'd0;
`endif
      end else begin
         s1_sync       <= bus.sync_in;
         s1_active     <= bus.active_in;
         s1_line_start <= bus.line_start;
         s1_strobe     <= bus.pixel_strobe;
`ifndef COMPOSITE_TEST_BARS_EN
         s1_luma       <= bus.luma_in;
`endif
         err_q         <= err_d;
         held_q        <= held_d;
         pin_code_q    <= pin_code_d;
         perr_q        <= perr_d;
`ifdef COMPOSITE_TEST_BARS_EN
         cnt_q         <= cnt_d;
`endif
      end
   end

   assign bus.output_450ohm  = pin_code_q[1];
   assign bus.output_900ohm  = pin_code_q[0];
   assign bus.protocol_error = perr_q;

endmodule
